seg7_scan: RTL and testbench

- Display scan driver for the Nexys3 4-digit common-anode 7-segment display.
- Consumes the divided scan clock from the display clock divider (~763 Hz, count bit 16), which it samples in the 100 MHz clk domain.
- Time-multiplexes four hex digits onto the shared segment bus.
- Provides a tear-free frame snapshot and an anti-ghosting guard interval.

---
 rtl/seg7_pkg.sv | 55 +++++
 rtl/seg7_edge_sync.sv | 30 +++
 rtl/seg7_scan.sv | 172 +++++++++++++++++
 tb/tb_seg7_scan.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph constants,
// scan FSM state type and the hex-to-segment decoder.
package seg7_pkg;

    // All segments off (active-low bus).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } seg7_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] glyph;
        case (hex)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_A;
            4'hB:    glyph = GLYPH_B;
            4'hC:    glyph = GLYPH_C;
            4'hD:    glyph = GLYPH_D;
            4'hE:    glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_edge_sync.sv
// Two-flop synchroniser for a slow asynchronous level, followed by a
// registered rising-edge detector. The pulse is one clk wide and appears
// three clk edges after the input rises; falling edges produce nothing.
module seg7_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronise, keep one delayed copy, and register the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
            pulse <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed scan driver for a common-anode 7-segment display.
// Each scan tick advances to the next digit after a guard interval with all
// anodes off (anti-ghosting). Digit data is latched into shadow registers
// once per frame so a frame is never torn by input changes.
// Optional build macro SEG7_LZB_EN adds leading-zero blanking at snapshot.
//
// state | meaning
// IDLE  | no tick seen since reset, display dark
// GUARD | all anodes off for GUARD_CYCLES clk after each digit advance
// DRIVE | current digit driven until the next tick
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0 = NUM_DIGITS'(1);

    seg7_state_t state;
    seg7_state_t state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] idx_inc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          tick;
    logic          snap;

    logic [3:0]            sh_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blank;
    logic [NUM_DIGITS-1:0] blank_cap;

    seg7_edge_sync u_scan_sync (
        .clk   (clk),
        .reset (reset),
        .din   (scan_clk),
        .pulse (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, digit index, guard down-counter and snapshot strobe.
    // A tick during GUARD still advances the index but restarts the guard,
    // so a digit is never driven for a truncated slot.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        snap      = 1'b0;
        idx_inc   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = GUARD;
                    idx_nxt   = '0;
                    cnt_nxt   = GUARD_LOAD;
                    snap      = 1'b1;
                end
            end
            GUARD: begin
                if (tick) begin
                    idx_nxt = idx_inc;
                    cnt_nxt = GUARD_LOAD;
                    snap    = (idx == IDX_LAST);
                end else if (cnt == '0) begin
                    state_nxt = DRIVE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DRIVE: begin
                if (tick) begin
                    state_nxt = GUARD;
                    idx_nxt   = idx_inc;
                    cnt_nxt   = GUARD_LOAD;
                    snap      = (idx == IDX_LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Blank mask captured at snapshot; optionally extended over leading zeros.
    always_comb begin
        blank_cap = blank;
`ifdef SEG7_LZB_EN
        begin : lzb
            logic lead;
            lead = 1'b1;
            for (int d = NUM_DIGITS - 1; d > 0; d--) begin
                if (lead && (value[4*d +: 4] == 4'h0) && !dp[d]) begin
                    blank_cap[d] = 1'b1;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    // Index, guard counter, frame snapshot and frame_done strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            cnt        <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            frame_done <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                sh_val[d] <= 4'h0;
            end
        end else begin
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            frame_done <= snap;
            if (snap) begin
                sh_dp    <= dp;
                sh_blank <= blank_cap;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    sh_val[d] <= value[4*d +: 4];
                end
            end
        end
    end

    // Registered display outputs derived from the current state and index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else if (state == DRIVE) begin
            an <= ~(DIGIT0 << idx);
            if (sh_blank[idx]) begin
                seg  <= SEG_BLANK;
                dp_n <= 1'b1;
            end else begin
                seg  <= hex_to_seg(sh_val[idx]);
                dp_n <= ~sh_dp[idx];
            end
        end else begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: reset, scan order and guard timing, frame
// snapshot isolation, dp/blank handling (leading-zero blanking when built
// with SEG7_LZB_EN), scan_clk glitches and reset during DRIVE.
`timescale 1ns/1ps
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_clk = 1'b0;
    logic [15:0] value = 16'h1234;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt = 0;
    int onehot_bad = 0;
    int cur = 0;
    bit started = 1'b0;
    int exp_fd_total = 0;
    int elapsed = 0;
    int hi_width = 0;

    // Hand-written active-low glyphs {g,f,e,d,c,b,a} for 0..F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.NUM_DIGITS(4), .GUARD_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_clk   (scan_clk),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses and any cycle with more than one anode on.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (!reset && ($countones(~an) > 1)) onehot_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clk, sampling 1 ns after the edge; drops scan_clk after hi_width clks.
    task automatic clk_step();
        @(posedge clk);
        #1;
        elapsed++;
        if (elapsed == hi_width) scan_clk = 1'b0;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One scan period: scan_clk high for 'width' clk (at least 32 clk of
    // period spent high-or-waiting), then 32 clk low. The tick reaches the FSM
    // on the 4th edge after the rise; 16 guard clks of dark anodes follow.
    task automatic scan_step(input int width, input logic [6:0] exp_seg,
                             input logic exp_dpn, input string tag);
        logic [3:0] one_hot;
        logic [3:0] exp_an;
        logic       exp_fd;
        int         guard;
        cur = started ? (cur + 1) % 4 : 0;
        started = 1'b1;
        exp_fd = (cur == 0);
        if (exp_fd) exp_fd_total++;
        one_hot = 4'b0001 << cur;
        exp_an = ~one_hot;
        elapsed = 0;
        hi_width = width;
        scan_clk = 1'b1;
        repeat (4) clk_step();
        check({tag, "_fd"}, {31'd0, frame_done}, {31'd0, exp_fd});
        guard = 0;
        clk_step();
        while (an == 4'hF && guard < 40) begin
            guard++;
            clk_step();
        end
        check({tag, "_guard"}, guard, 16);
        check({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
        check({tag, "_dpn"}, {31'd0, dp_n}, {31'd0, exp_dpn});
        while (elapsed < 32) clk_step();
        scan_clk = 1'b0;
        idle_clks(32);
    endtask

    // Two rises 6 clk apart: the second tick lands in GUARD, advancing the
    // index again and restarting the guard. Counting from the edge after the
    // second rise: 4 clk until that tick is consumed, then 16 guard clks.
    task automatic guard_tick_step(input logic [6:0] exp_seg, input string tag);
        logic [3:0] one_hot;
        logic [3:0] exp_an;
        int         guard;
        cur = (cur + 2) % 4;
        one_hot = 4'b0001 << cur;
        exp_an = ~one_hot;
        elapsed = 0;
        hi_width = 0;
        scan_clk = 1'b1;
        idle_clks(2);
        scan_clk = 1'b0;
        idle_clks(4);
        scan_clk = 1'b1;
        guard = 0;
        clk_step();
        while (an == 4'hF && guard < 40) begin
            guard++;
            clk_step();
        end
        check({tag, "_guard"}, guard, 20);
        check({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
        idle_clks(10);
        scan_clk = 1'b0;
        idle_clks(32);
    endtask

    initial begin
        // Reset with scan_clk toggling.
        #3 reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i % 3 == 0) scan_clk = ~scan_clk;
        end
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dpn", {31'd0, dp_n}, 32'd1);
        check("rst_fd_cnt", fd_cnt, 0);
        scan_clk = 1'b0;
        idle_clks(3);
        reset = 1'b0;
        idle_clks(20);
        check("idle_an", {28'd0, an}, 32'hF);
        check("idle_fd_cnt", fd_cnt, 0);

        // Frame 1 and start of frame 2: 1234.
        scan_step(32, glyph[4], 1'b1, "f1d0");
        scan_step(32, glyph[3], 1'b1, "f1d1");
        scan_step(32, glyph[2], 1'b1, "f1d2");
        scan_step(32, glyph[1], 1'b1, "f1d3");
        scan_step(32, glyph[4], 1'b1, "f2d0");
        scan_step(32, glyph[3], 1'b1, "f2d1");

        // Mid-frame change must not tear the frame in progress.
        value = 16'hABCD;
        scan_step(32, glyph[2], 1'b1, "f2d2");
        scan_step(32, glyph[1], 1'b1, "f2d3");
        scan_step(32, glyph[13], 1'b1, "f3d0");
        value = 16'h0070;
        scan_step(32, glyph[12], 1'b1, "f3d1");
        scan_step(32, glyph[11], 1'b1, "f3d2");
        scan_step(32, glyph[10], 1'b1, "f3d3");

        // 0070, no dp, no blank.
        scan_step(32, glyph[0], 1'b1, "f4d0");
        dp = 4'b0100;
        blank = 4'b0001;
        scan_step(32, glyph[7], 1'b1, "f4d1");
`ifdef SEG7_LZB_EN
        scan_step(32, 7'h7F, 1'b1, "f4d2");
        scan_step(32, 7'h7F, 1'b1, "f4d3");
`else
        scan_step(32, glyph[0], 1'b1, "f4d2");
        scan_step(32, glyph[0], 1'b1, "f4d3");
`endif

        // 0070, dp on digit 2, digit 0 forced blank.
        scan_step(32, 7'h7F, 1'b1, "f5d0");
        value = 16'h1234;
        dp = 4'h0;
        blank = 4'h0;
        scan_step(32, glyph[7], 1'b1, "f5d1");
        scan_step(32, glyph[0], 1'b0, "f5d2");
`ifdef SEG7_LZB_EN
        scan_step(32, 7'h7F, 1'b1, "f5d3");
`else
        scan_step(32, glyph[0], 1'b1, "f5d3");
`endif

        // One-clk scan_clk pulse yields exactly one tick (wraps here).
        scan_step(1, glyph[4], 1'b1, "glitch");
        // Extra tick during GUARD: index 0 -> 2 without driving digit 1.
        guard_tick_step(glyph[2], "gtick");
        scan_step(32, glyph[1], 1'b1, "f6d3");

        // Reset while digit 3 is driven.
        check("pre_rst_an", {28'd0, an}, 32'h7);
        reset = 1'b1;
        #1;
        check("mid_rst_an", {28'd0, an}, 32'hF);
        check("mid_rst_seg", {25'd0, seg}, 32'h7F);
        check("mid_rst_dpn", {31'd0, dp_n}, 32'd1);
        check("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        value = 16'h5678;
        dp = 4'b0001;
        idle_clks(3);
        reset = 1'b0;
        started = 1'b0;
        idle_clks(5);
        check("post_rst_an", {28'd0, an}, 32'hF);
        scan_step(32, glyph[8], 1'b0, "rst_d0");
        scan_step(32, glyph[7], 1'b1, "rst_d1");

        check("fd_total", fd_cnt, exp_fd_total);
        check("an_onehot", onehot_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
